// File: rtl/ck_riscv_pkg.sv
// Shared CK_riscv definitions: data width, memory access size encodings,
// LSU state encoding and the alignment rule used by the MEM stage.
package ck_riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] MEM_SIZE_B = 2'b00;
  localparam logic [1:0] MEM_SIZE_H = 2'b01;
  localparam logic [1:0] MEM_SIZE_W = 2'b10;  // 2'b11 is handled as a word

  typedef enum logic [1:0] {
    LSU_IDLE        = 2'd0,
    LSU_WAIT_GNT    = 2'd1,
    LSU_WAIT_RVALID = 2'd2
  } lsu_state_e;

  // Halves need addr[0]=0, words (and the 2'b11 alias) need addr[1:0]=0.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      MEM_SIZE_B: is_misaligned = 1'b0;
      MEM_SIZE_H: is_misaligned = off[0];
      default:    is_misaligned = (off != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// req/gnt/rvalid data bus between the LSU (master) and memory (slave).
interface mem_lsu_if;
  import ck_riscv_pkg::*;

  logic            req;
  logic            we;
  logic [XLEN-1:0] addr;
  logic [3:0]      be;
  logic [XLEN-1:0] wdata;
  logic            gnt;
  logic            rvalid;
  logic [XLEN-1:0] rdata;

  modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_lsu_fmt.sv
// Lane formatting for one access: byte enables and replicated store data
// from size/offset, plus lane extraction and sign/zero extension of load data.
module mem_lsu_fmt
  import ck_riscv_pkg::*;
(
  input  logic [1:0]      i_size,
  input  logic [1:0]      i_off,
  input  logic            i_unsigned,
  input  logic [XLEN-1:0] i_sdata,
  input  logic [XLEN-1:0] i_rdata,
  output logic [3:0]      o_be,
  output logic [XLEN-1:0] o_wdata,
  output logic [XLEN-1:0] o_ldata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rdata[{i_off, 3'b000} +: 8];
  assign w_half = i_rdata[{i_off[1], 4'b0000} +: 16];

  // Size decode: store lanes are replicated so the enables alone pick the target bytes.
  always_comb begin
    o_be    = 4'b1111;
    o_wdata = i_sdata;
    o_ldata = i_rdata;
    case (i_size)
      MEM_SIZE_B: begin
        o_be    = 4'b0001 << i_off;
        o_wdata = {4{i_sdata[7:0]}};
        o_ldata = {{24{~i_unsigned & w_byte[7]}}, w_byte};
      end
      MEM_SIZE_H: begin
        o_be    = 4'b0011 << i_off;
        o_wdata = {2{i_sdata[15:0]}};
        o_ldata = {{16{~i_unsigned & w_half[15]}}, w_half};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: issues EX/MEM memory commands on the data bus,
// stalls the pipeline while a transaction is open, formats and registers
// load data for WB, and flags misaligned accesses and bus timeouts.
module mem_lsu
  import ck_riscv_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            mem_rd_in,
  input  logic            mem_wr_in,
  input  logic [1:0]      mem_size_in,
  input  logic            mem_unsigned_in,
  input  logic [XLEN-1:0] alu_ex_result_in,
  input  logic [XLEN-1:0] store_data_in,
  mem_lsu_if.master       dbus,
  output logic            lsu_stall,
  output logic [XLEN-1:0] load_data_out,
  output logic            misalign_exc,
  output logic            bus_err
);

  localparam int CW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  lsu_state_e      r_state;
  logic            r_we;
  logic [XLEN-1:0] r_addr;
  logic [1:0]      r_size;
  logic [1:0]      r_off;
  logic            r_uns;
  logic [3:0]      r_be;
  logic [XLEN-1:0] r_wdata;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_ldata;
  logic            r_misalign;
  logic            r_bus_err;

  logic            w_cmd, w_mis, w_go, w_to;
  logic [3:0]      w_st_be;
  logic [XLEN-1:0] w_st_wdata, w_ld_data;
  logic [XLEN-1:0] w_unused_ld, w_unused_wdata;
  logic [3:0]      w_unused_be;

  assign w_cmd = mem_rd_in | mem_wr_in;
  assign w_mis = w_cmd & is_misaligned(mem_size_in, alu_ex_result_in[1:0]);
  assign w_go  = w_cmd & ~w_mis;
  assign w_to  = (TIMEOUT_CYC != 0) && (r_cnt == CW'(TIMEOUT_CYC));

  // Store side: formats the incoming EX/MEM command for same-cycle issue.
  mem_lsu_fmt u_fmt_st (
    .i_size     (mem_size_in),
    .i_off      (alu_ex_result_in[1:0]),
    .i_unsigned (mem_unsigned_in),
    .i_sdata    (store_data_in),
    .i_rdata    ('0),
    .o_be       (w_st_be),
    .o_wdata    (w_st_wdata),
    .o_ldata    (w_unused_ld)
  );

  // Load side: extracts returned data using the latched access shape.
  mem_lsu_fmt u_fmt_ld (
    .i_size     (r_size),
    .i_off      (r_off),
    .i_unsigned (r_uns),
    .i_sdata    (r_wdata),
    .i_rdata    (dbus.rdata),
    .o_be       (w_unused_be),
    .o_wdata    (w_unused_wdata),
    .o_ldata    (w_ld_data)
  );

  // Bus drive and stall: IDLE issues straight from the inputs, WAIT_GNT replays latched fields.
  always_comb begin
    dbus.req   = 1'b0;
    dbus.we    = 1'b0;
    dbus.addr  = '0;
    dbus.be    = '0;
    dbus.wdata = '0;
    lsu_stall  = 1'b0;
    case (r_state)
      LSU_IDLE: if (w_go) begin
        dbus.req   = 1'b1;
        dbus.we    = mem_wr_in;
        dbus.addr  = {alu_ex_result_in[XLEN-1:2], 2'b00};
        dbus.be    = w_st_be;
        dbus.wdata = w_st_wdata;
        lsu_stall  = ~(dbus.gnt & mem_wr_in);
      end
      LSU_WAIT_GNT: begin
        dbus.req   = 1'b1;
        dbus.we    = r_we;
        dbus.addr  = r_addr;
        dbus.be    = r_be;
        dbus.wdata = r_wdata;
        lsu_stall  = dbus.gnt ? ~r_we : ~w_to;
      end
      LSU_WAIT_RVALID: lsu_stall = ~dbus.rvalid & ~w_to;
      default: ;
    endcase
  end

  // Transaction FSM with registered load data and exception pulses; a bus response beats a same-cycle timeout.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= LSU_IDLE;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_size     <= '0;
      r_off      <= '0;
      r_uns      <= 1'b0;
      r_be       <= '0;
      r_wdata    <= '0;
      r_cnt      <= '0;
      r_ldata    <= '0;
      r_misalign <= 1'b0;
      r_bus_err  <= 1'b0;
    end else begin
      r_misalign <= 1'b0;
      r_bus_err  <= 1'b0;
      case (r_state)
        LSU_IDLE: begin
          if (w_mis) begin
            r_misalign <= 1'b1;
          end else if (w_go) begin
            r_we    <= mem_wr_in;
            r_addr  <= {alu_ex_result_in[XLEN-1:2], 2'b00};
            r_size  <= mem_size_in;
            r_off   <= alu_ex_result_in[1:0];
            r_uns   <= mem_unsigned_in;
            r_be    <= w_st_be;
            r_wdata <= w_st_wdata;
            r_cnt   <= '0;
            if (dbus.gnt) r_state <= mem_wr_in ? LSU_IDLE : LSU_WAIT_RVALID;
            else          r_state <= LSU_WAIT_GNT;
          end
        end
        LSU_WAIT_GNT: begin
          if (dbus.gnt) begin
            r_state <= r_we ? LSU_IDLE : LSU_WAIT_RVALID;
            r_cnt   <= '0;
          end else if (w_to) begin
            r_state   <= LSU_IDLE;
            r_bus_err <= 1'b1;
            if (!r_we) r_ldata <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        LSU_WAIT_RVALID: begin
          if (dbus.rvalid) begin
            r_ldata <= w_ld_data;
            r_state <= LSU_IDLE;
          end else if (w_to) begin
            r_state   <= LSU_IDLE;
            r_bus_err <= 1'b1;
            r_ldata   <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= LSU_IDLE;
      endcase
    end
  end

  assign load_data_out = r_ldata;
  assign misalign_exc  = r_misalign;
  assign bus_err       = r_bus_err;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: stimulus pushes expected bus transactions and
// exception pulses into queues; a negedge monitor pops and compares them.
module tb_mem_lsu;
  import ck_riscv_pkg::*;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic        rd, wr, uns;
  logic [1:0]  size;
  logic [31:0] addr, sdata;
  logic        stall, mis, berr;
  logic [31:0] ld;

  int   n_chk = 0;
  int   n_fail = 0;
  bus_t exp_bus[$];
  int   exp_evt[$];   // 1 = misalign_exc, 2 = bus_err

  mem_lsu_if dbus_if ();

  mem_lsu #(.TIMEOUT_CYC(4)) dut (
    .clk              (clk),
    .rstn             (rstn),
    .mem_rd_in        (rd),
    .mem_wr_in        (wr),
    .mem_size_in      (size),
    .mem_unsigned_in  (uns),
    .alu_ex_result_in (addr),
    .store_data_in    (sdata),
    .dbus             (dbus_if),
    .lsu_stall        (stall),
    .load_data_out    (ld),
    .misalign_exc     (mis),
    .bus_err          (berr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd = 0; wr = 0; uns = 0; size = 0; addr = 0; sdata = 0;
    dbus_if.gnt = 0; dbus_if.rvalid = 0;
  endtask

  task automatic cmd(input logic r, input logic w, input logic [1:0] s, input logic u,
                     input logic [31:0] a, input logic [31:0] d, input logic g);
    rd = r; wr = w; size = s; uns = u; addr = a; sdata = d; dbus_if.gnt = g;
  endtask

  task automatic push_bus(input logic w, input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
    bus_t e;
    e.we = w; e.addr = a; e.be = b; e.wdata = d;
    exp_bus.push_back(e);
  endtask

  // Monitor: every accepted bus request and every exception pulse must match the next expectation.
  always @(negedge clk) begin
    if (rstn) begin
      if (dbus_if.req && dbus_if.gnt) begin
        if (exp_bus.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL bus_txn: unexpected request addr %h, expected none", dbus_if.addr);
        end else begin
          bus_t e;
          e = exp_bus.pop_front();
          chk("bus_we", {31'b0, dbus_if.we}, {31'b0, e.we});
          chk("bus_addr", dbus_if.addr, e.addr);
          chk("bus_be", {28'b0, dbus_if.be}, {28'b0, e.be});
          if (e.we) chk("bus_wdata", dbus_if.wdata, e.wdata);
        end
      end
      if (mis || berr) begin
        if (exp_evt.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL evt: unexpected pulse mis=%0b berr=%0b, expected none", mis, berr);
        end else begin
          int ev;
          ev = exp_evt.pop_front();
          chk("evt_kind", {30'b0, berr, mis}, (ev == 1) ? 32'd1 : 32'd2);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1);
  end

  initial begin
    rstn = 0;
    idle();
    dbus_if.rdata = 0;
    repeat (2) @(negedge clk);
    chk("rst_stall", {31'b0, stall}, 0);
    chk("rst_req", {31'b0, dbus_if.req}, 0);
    chk("rst_addr", dbus_if.addr, 0);
    chk("rst_be", {28'b0, dbus_if.be}, 0);
    chk("rst_wdata", dbus_if.wdata, 0);
    chk("rst_ld", ld, 0);
    chk("rst_exc", {30'b0, berr, mis}, 0);
    rstn = 1;

    // SW 0x104, granted immediately: zero-stall store
    cyc(); cmd(0, 1, MEM_SIZE_W, 0, 32'h104, 32'hDEADBEEF, 1);
    push_bus(1, 32'h104, 4'hF, 32'hDEADBEEF);
    @(negedge clk); chk("sw_stall", {31'b0, stall}, 0);
    // Back-to-back: rd+wr together -> store wins, SB to 0x7
    cyc(); cmd(1, 1, MEM_SIZE_B, 0, 32'h7, 32'h5A, 1);
    push_bus(1, 32'h4, 4'b1000, 32'h5A5A5A5A);
    @(negedge clk); chk("rdwr_stall", {31'b0, stall}, 0);
    cyc(); idle();
    @(negedge clk); chk("idle_req", {31'b0, dbus_if.req}, 0);

    // LB / LBU 0x203, rvalid two cycles after grant
    for (int k = 0; k < 2; k++) begin
      cyc(); cmd(1, 0, MEM_SIZE_B, k[0], 32'h203, 32'h0, 1);
      push_bus(0, 32'h200, 4'b1000, 32'h0);
      @(negedge clk); chk("lb_stall_c0", {31'b0, stall}, 1);
      cyc(); idle();
      @(negedge clk); chk("lb_stall_c1", {31'b0, stall}, 1);
      cyc(); dbus_if.rvalid = 1; dbus_if.rdata = 32'h80FF0000;
      @(negedge clk); chk("lb_stall_c2", {31'b0, stall}, 0);
      cyc(); dbus_if.rvalid = 0;
      @(negedge clk); chk(k ? "lbu_data" : "lb_data", ld, k ? 32'h00000080 : 32'hFFFFFF80);
    end

    // SH 0x12, grant delayed 3 cycles: request fields held steady
    cyc(); cmd(0, 1, MEM_SIZE_H, 0, 32'h12, 32'h0000ABCD, 0);
    push_bus(1, 32'h10, 4'b1100, 32'hABCDABCD);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) cyc();
      dbus_if.gnt = (i == 3);
      @(negedge clk);
      chk("sh_req", {31'b0, dbus_if.req}, 1);
      chk("sh_addr", dbus_if.addr, 32'h10);
      chk("sh_be", {28'b0, dbus_if.be}, 32'hC);
      chk("sh_wdata", dbus_if.wdata, 32'hABCDABCD);
      chk("sh_stall", {31'b0, stall}, (i < 3) ? 32'd1 : 32'd0);
    end
    cyc(); idle();
    @(negedge clk); chk("sh_done_stall", {31'b0, stall}, 0);

    // LW 0x101 misaligned: dropped, one-cycle pulse
    cyc(); cmd(1, 0, MEM_SIZE_W, 0, 32'h101, 32'h0, 0);
    exp_evt.push_back(1);
    @(negedge clk);
    chk("mis_req", {31'b0, dbus_if.req}, 0);
    chk("mis_stall", {31'b0, stall}, 0);
    cyc(); idle();
    @(negedge clk);
    chk("mis_pulse", {31'b0, mis}, 1);
    chk("mis_ld_kept", ld, 32'h00000080);
    cyc();
    @(negedge clk); chk("mis_pulse_end", {31'b0, mis}, 0);

    // LW 0x20 with no rvalid: abort on the 5th wait cycle
    cyc(); cmd(1, 0, MEM_SIZE_W, 0, 32'h20, 32'h0, 1);
    push_bus(0, 32'h20, 4'hF, 32'h0);
    @(negedge clk); chk("to_stall_c0", {31'b0, stall}, 1);
    for (int i = 1; i <= 5; i++) begin
      cyc();
      if (i == 1) idle();
      @(negedge clk); chk("to_stall", {31'b0, stall}, (i < 5) ? 32'd1 : 32'd0);
    end
    exp_evt.push_back(2);
    cyc();
    @(negedge clk);
    chk("to_berr", {31'b0, berr}, 1);
    chk("to_ld_zero", ld, 0);
    // Next SW issues normally from IDLE
    cyc(); cmd(0, 1, MEM_SIZE_W, 0, 32'h40, 32'h11223344, 1);
    push_bus(1, 32'h40, 4'hF, 32'h11223344);
    @(negedge clk);
    chk("to_berr_end", {31'b0, berr}, 0);
    chk("post_to_sw_stall", {31'b0, stall}, 0);
    cyc(); idle();

    // LW 0x30 to leave non-zero load data, then reset during an LH
    cyc(); cmd(1, 0, MEM_SIZE_W, 0, 32'h30, 32'h0, 1);
    push_bus(0, 32'h30, 4'hF, 32'h0);
    cyc(); idle();
    cyc(); dbus_if.rvalid = 1; dbus_if.rdata = 32'h12345678;
    cyc(); dbus_if.rvalid = 0;
    @(negedge clk); chk("lw_data", ld, 32'h12345678);
    cyc(); cmd(1, 0, MEM_SIZE_H, 0, 32'h2, 32'h0, 1);
    push_bus(0, 32'h0, 4'b1100, 32'h0);
    cyc(); idle();
    @(negedge clk); chk("lh_stall", {31'b0, stall}, 1);
    #2 rstn = 0;
    #1;
    chk("rst_mid_stall", {31'b0, stall}, 0);
    chk("rst_mid_ld", ld, 0);
    @(negedge clk); rstn = 1;
    cyc(); dbus_if.rvalid = 1; dbus_if.rdata = 32'hFFFF0000;
    @(negedge clk);
    chk("late_rv_stall", {31'b0, stall}, 0);
    chk("late_rv_req", {31'b0, dbus_if.req}, 0);
    cyc(); dbus_if.rvalid = 0;
    @(negedge clk); chk("late_rv_ld", ld, 0);

    chk("bus_queue_drained", exp_bus.size(), 0);
    chk("evt_queue_drained", exp_evt.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
